// File: rtl/fb_rect_writer.sv
// Solid-colour rectangle fill into the 320x240 RGB444 background frame buffer.
// One clipped pixel per wr_allow cycle, raster order, registered BRAM port A.
module fb_rect_writer #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         x0,
  input  logic [7:0]         y0,
  input  logic [8:0]         w,
  input  logic [7:0]         h,
  input  logic [COLOR_W-1:0] color,
  input  logic               wr_allow,
  output logic               busy,
  output logic               done,
  output logic               we,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } state_t;

  localparam logic [9:0] FB_W10 = 10'(FB_W);
  localparam logic [9:0] FB_H10 = 10'(FB_H);

  state_t state, state_nxt;

  logic [8:0]         x_start;
  logic [8:0]         x_end;
  logic [7:0]         y_end;
  logic [8:0]         cur_x;
  logic [7:0]         cur_y;
  logic [ADDR_W-1:0]  row_base;
  logic [COLOR_W-1:0] color_l;

  logic [9:0] x_sum, y_sum;
  logic [9:0] x_lim, y_lim;
  logic       degen;
  logic       at_row_end;
  logic       at_last;

  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {2'b0, y0} + {2'b0, h};
    x_lim = (x_sum > FB_W10) ? FB_W10 : x_sum;
    y_lim = (y_sum > FB_H10) ? FB_H10 : y_sum;
    degen = (w == '0) || (h == '0) ||
            ({1'b0, x0} >= FB_W10) ||
            ({2'b0, y0} >= FB_H10);
  end

  assign at_row_end = (cur_x == x_end);
  assign at_last    = at_row_end && (cur_y == y_end);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = degen ? DONE : SETUP;
      SETUP: state_nxt = FILL;
      FILL:  if (wr_allow && at_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      we       <= 1'b0;
      addr     <= '0;
      dout     <= '0;
      x_start  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
      color_l  <= '0;
    end else begin
      state <= state_nxt;
      we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_start <= x0;
            cur_x   <= x0;
            cur_y   <= y0;
            color_l <= color;
            x_end   <= 9'(x_lim - 10'd1);
            y_end   <= 8'(y_lim - 10'd1);
          end
        end
        SETUP: begin
          // y*320 as (y<<8)+(y<<6)
          row_base <= ADDR_W'({cur_y, 8'b0}) + ADDR_W'({cur_y, 6'b0});
          cur_x    <= x_start;
        end
        FILL: begin
          if (wr_allow) begin
            we   <= 1'b1;
            addr <= row_base + ADDR_W'(cur_x);
            dout <= color_l;
            if (!at_row_end) begin
              cur_x <= cur_x + 9'd1;
            end else begin
              cur_x    <= x_start;
              cur_y    <= cur_y + 8'd1;
              row_base <= row_base + ADDR_W'(FB_W);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: command table, write scoreboard,
// plus gating, start-while-busy and mid-fill reset sequences.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x0 = '0;
  logic [7:0]  y0 = '0;
  logic [8:0]  w = '0;
  logic [7:0]  h = '0;
  logic [11:0] color = '0;
  logic        wr_allow = 1'b1;
  logic        busy, done, we;
  logic [16:0] addr;
  logic [11:0] dout;

  fb_rect_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
    .wr_allow(wr_allow), .busy(busy), .done(done),
    .we(we), .addr(addr), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int color;
  } wr_t;

  typedef struct {
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [11:0] color;
    int          n;
    int          last;
    int          mode;
  } vec_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  fails = 0;
  int  nwr = 0;
  int  last_addr = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      checks++;
      nwr++;
      last_addr = int'(addr);
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0d expected none", addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(addr) != e.addr || int'(dout) != e.color) begin
          fails++;
          $display("FAIL write: got addr %0d dout %h expected addr %0d dout %h",
                   addr, dout, e.addr, e.color);
        end
      end
    end
  end

  task automatic push_model(input vec_t c);
    int xe, ye;
    if (c.w == 0 || c.h == 0 || c.x0 >= 320 || c.y0 >= 240) return;
    xe = (int'(c.x0) + int'(c.w) > 320) ? 319 : int'(c.x0) + int'(c.w) - 1;
    ye = (int'(c.y0) + int'(c.h) > 240) ? 239 : int'(c.y0) + int'(c.h) - 1;
    for (int y = int'(c.y0); y <= ye; y++)
      for (int x = int'(c.x0); x <= xe; x++)
        exp_q.push_back('{addr: y * 320 + x, color: int'(c.color)});
  endtask

  // mode: 0 plain, 1 gate 3 cycles after first write, 2 start pulse while busy
  task automatic run_cmd(input vec_t c);
    int  cyc;
    int  gated;
    bit  seen;
    push_model(c);
    nwr = 0;
    last_addr = -1;
    gated = 0;
    x0 = c.x0; y0 = c.y0; w = c.w; h = c.h; color = c.color;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", int'(busy), 1);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 80000) begin
      if (done) begin
        seen = 1;
      end else begin
        if (c.mode == 1 && gated == 0 && we && nwr == 1) begin
          gated = 1;
          wr_allow = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            cyc++;
            chk("we_gated", int'(we), 0);
          end
          wr_allow = 1'b1;
        end else if (c.mode == 2 && nwr == 2 && gated == 0) begin
          gated = 1;
          x0 = 9'd0; y0 = 8'd0; w = 9'd7; h = 8'd7; color = 12'h0F0;
          start = 1'b1;
          @(negedge clk); #1;
          start = 1'b0;
          cyc++;
        end else begin
          @(negedge clk); #1;
          cyc++;
        end
      end
    end
    chk("done_seen", int'(seen), 1);
    if (c.mode != 1)
      chk("done_latency", cyc, (c.n == 0) ? 0 : c.n + 1);
    else
      chk("done_latency_gated", cyc, c.n + 4);
    chk("we_with_done", int'(we), (c.n > 0) ? 1 : 0);
    @(negedge clk); #1;
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    chk("write_count", nwr, c.n);
    chk("queue_empty", exp_q.size(), 0);
    if (c.n > 0) chk("last_addr", last_addr, c.last);
    if (c.mode == 2) begin
      for (int k = 0; k < 12; k++) begin
        @(negedge clk); #1;
        chk("no_queued_cmd", int'(busy | done), 0);
      end
    end
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{9'd5,   8'd2,   9'd1,   8'd1,   12'hF00, 1,     645,   0};
    tbl[1]  = '{9'd318, 8'd238, 9'd4,   8'd4,   12'h0A5, 4,     76799, 0};
    tbl[2]  = '{9'd0,   8'd0,   9'd3,   8'd1,   12'h123, 3,     2,     1};
    tbl[3]  = '{9'd0,   8'd5,   9'd0,   8'd3,   12'hFFF, 0,     0,     0};
    tbl[4]  = '{9'd320, 8'd5,   9'd4,   8'd3,   12'hFFF, 0,     0,     0};
    tbl[5]  = '{9'd10,  8'd5,   9'd4,   8'd0,   12'hFFF, 0,     0,     0};
    tbl[6]  = '{9'd10,  8'd240, 9'd4,   8'd3,   12'hFFF, 0,     0,     0};
    tbl[7]  = '{9'd10,  8'd20,  9'd5,   8'd3,   12'h456, 15,    7054,  2};
    tbl[8]  = '{9'd300, 8'd0,   9'd50,  8'd2,   12'h789, 40,    639,   0};
    tbl[9]  = '{9'd0,   8'd239, 9'd3,   8'd10,  12'hABC, 3,     76482, 0};
    tbl[10] = '{9'd511, 8'd255, 9'd511, 8'd255, 12'h00F, 0,     0,     0};
    tbl[11] = '{9'd0,   8'd0,   9'd320, 8'd240, 12'hDEF, 76800, 76799, 0};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", int'(we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_dout", int'(dout), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_cmd(tbl[i]);
      @(negedge clk);
    end

    // reset in the middle of a fill
    begin
      vec_t c;
      c = '{9'd0, 9'd0, 9'd100, 8'd10, 12'h321, 1000, 0, 0};
      push_model(c);
      x0 = c.x0; y0 = c.y0; w = c.w; h = c.h; color = c.color;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("midrst_we", int'(we), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_addr", int'(addr), 0);
      exp_q.delete();
      @(negedge clk); #1;
      chk("midrst_we2", int'(we), 0);
      rst = 1'b1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk); #1;
        chk("post_rst_idle", int'(busy | done | we), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
